// File: rtl/prio_sched_pkg.sv
// rtl/prio_sched_pkg.sv - shared types, sizes and tree value packing for prio_sched
package prio_sched_pkg;

  localparam int N_SRC  = 8;
  localparam int PRIO_W = 8;
  localparam int DEPTH  = 8;
  localparam int ID_W   = 3;

  typedef logic [PRIO_W-1:0] prio_t;
  typedef logic [ID_W-1:0]   src_id_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OFFER  = 2'd1,
    SETTLE = 2'd2
  } sched_state_e;

  // Inverted index in the low bits makes every value unique and lets the lower index win ties.
  function automatic logic [31:0] pack_val(prio_t prio, src_id_t idx);
    return {prio, 21'b0, ~idx};
  endfunction

endpackage

// File: rtl/prio_sched_if.sv
// rtl/prio_sched_if.sv - core offer/return handshake and configuration bus for prio_sched
interface prio_sched_if;
  import prio_sched_pkg::*;

  logic    irq_valid;
  src_id_t irq_id;
  prio_t   irq_prio;
  logic    irq_ready;
  logic    irq_done;
  logic    cfg_we;
  src_id_t cfg_idx;
  prio_t   cfg_prio;
  logic    cfg_en;

  modport master (
    input  irq_valid, irq_id, irq_prio,
    output irq_ready, irq_done, cfg_we, cfg_idx, cfg_prio, cfg_en
  );

  modport slave (
    output irq_valid, irq_id, irq_prio,
    input  irq_ready, irq_done, cfg_we, cfg_idx, cfg_prio, cfg_en
  );

endinterface

// File: rtl/tree.sv
// rtl/tree.sv - three-level max-index comparator over eight 32-bit values
module tree (
  input  logic [7:0][31:0] val,
  output logic [2:0]       idx
);

  logic [3:0][31:0] v1;
  logic [3:0][2:0]  i1;
  logic [1:0][31:0] v2;
  logic [1:0][2:0]  i2;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      if (val[2*k+1] > val[2*k]) begin
        v1[k] = val[2*k+1];
        i1[k] = 3'(2*k+1);
      end else begin
        v1[k] = val[2*k];
        i1[k] = 3'(2*k);
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (v1[2*k+1] > v1[2*k]) begin
        v2[k] = v1[2*k+1];
        i2[k] = i1[2*k+1];
      end else begin
        v2[k] = v1[2*k];
        i2[k] = i1[2*k];
      end
    end
    idx = (v2[1] > v2[0]) ? i2[1] : i2[0];
  end

endmodule

// File: rtl/prio_sched.sv
// rtl/prio_sched.sv - 8-source priority interrupt scheduler with nesting stack
module prio_sched
  import prio_sched_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  prio_sched_if.slave      bus,
  output prio_t            cur_level,
  output logic             err
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_OFFER  = OFFER;
  localparam logic [1:0] S_SETTLE = SETTLE;

  logic [N_SRC-1:0]       irq_prev, pending, en, elig, edge_det, clr_mask;
  prio_t                  prio [N_SRC];
  logic [N_SRC-1:0][31:0] val;
  src_id_t                win_idx;
  prio_t                  win_prio;
  src_id_t                cand_id;
  prio_t                  cand_prio;
  logic                   cand_ok;
  logic [1:0]             state;
  logic                   valid_q;
  src_id_t                id_q;
  prio_t                  prio_q;
  prio_t                  stack [DEPTH];
  logic [SP_W-1:0]        sp, sp_dec;
  logic                   hs, stack_full;

  assign bus.irq_valid = valid_q;
  assign bus.irq_id    = id_q;
  assign bus.irq_prio  = prio_q;

  always_comb begin
    edge_det = irq_in & ~irq_prev;
    for (int i = 0; i < N_SRC; i++) begin
      elig[i] = pending[i] & en[i] & (prio[i] != '0);
      val[i]  = elig[i] ? pack_val(prio[i], src_id_t'(i)) : 32'h0;
    end
  end

  tree u_tree (
    .val (val),
    .idx (win_idx)
  );

  always_comb begin
    win_prio   = elig[win_idx] ? prio[win_idx] : '0;
    hs         = valid_q & bus.irq_ready;
    clr_mask   = '0;
    if (hs) clr_mask[id_q] = 1'b1;
    stack_full = (sp == SP_W'(DEPTH));
    sp_dec     = sp - SP_W'(1);
  end

  // A new edge on the source being accepted re-arms it: set beats clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_prev  <= '0;
      pending   <= '0;
      en        <= '0;
      for (int i = 0; i < N_SRC; i++) prio[i] <= '0;
      cand_id   <= '0;
      cand_prio <= '0;
      cand_ok   <= 1'b0;
    end else begin
      irq_prev <= irq_in;
      pending  <= (pending & ~clr_mask) | edge_det;
      if (bus.cfg_we) begin
        prio[bus.cfg_idx] <= bus.cfg_prio;
        en[bus.cfg_idx]   <= bus.cfg_en;
      end
      cand_id   <= win_idx;
      cand_prio <= win_prio;
      cand_ok   <= (win_prio > cur_level) && !stack_full;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      valid_q <= 1'b0;
      id_q    <= '0;
      prio_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cand_ok) begin
            state   <= S_OFFER;
            valid_q <= 1'b1;
            id_q    <= cand_id;
            prio_q  <= cand_prio;
          end
        end
        S_OFFER: begin
          if (hs) begin
            state   <= S_SETTLE;
            valid_q <= 1'b0;
            id_q    <= '0;
            prio_q  <= '0;
          end else if (!cand_ok) begin
            state   <= S_IDLE;
            valid_q <= 1'b0;
            id_q    <= '0;
            prio_q  <= '0;
          end else begin
            id_q   <= cand_id;
            prio_q <= cand_prio;
          end
        end
        // Candidate registers still hold pre-accept state here; skip one cycle.
        S_SETTLE: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
      sp        <= '0;
      cur_level <= '0;
      err       <= 1'b0;
    end else if (hs) begin
      stack[sp[IDX_W-1:0]] <= cur_level;
      sp                   <= sp + SP_W'(1);
      cur_level            <= prio_q;
      if (bus.irq_done) err <= 1'b1;
    end else if (bus.irq_done) begin
      if (sp == '0) begin
        err <= 1'b1;
      end else begin
        cur_level <= stack[sp_dec[IDX_W-1:0]];
        sp        <= sp_dec;
      end
    end
  end

endmodule

// File: tb/tb_prio_sched.sv
// tb/tb_prio_sched.sv - scoreboard bench for prio_sched
module tb_prio_sched;
  import prio_sched_pkg::*;

  typedef struct packed {
    src_id_t id;
    prio_t   prio;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [N_SRC-1:0] irq_in;
  prio_t            cur_level;
  logic             err;
  exp_t             sb[$];
  int               n_chk = 0;
  int               n_fail = 0;

  prio_sched_if bus();

  prio_sched dut (
    .clk       (clk),
    .reset     (reset),
    .irq_in    (irq_in),
    .bus       (bus),
    .cur_level (cur_level),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int id, input int p);
    sb.push_back({src_id_t'(id), prio_t'(p)});
  endtask

  task automatic cfg(input int idx, input int p, input bit e);
    bus.cfg_we   = 1'b1;
    bus.cfg_idx  = src_id_t'(idx);
    bus.cfg_prio = prio_t'(p);
    bus.cfg_en   = e;
    @(negedge clk);
    bus.cfg_we   = 1'b0;
  endtask

  task automatic pulse(input logic [N_SRC-1:0] m);
    irq_in = m;
    @(negedge clk);
    irq_in = '0;
  endtask

  task automatic lat2(input string tag);
    chk({tag, "_lat0"}, 32'(bus.irq_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_lat1"}, 32'(bus.irq_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_lat2"}, 32'(bus.irq_valid), 32'd1);
  endtask

  task automatic wait_offer(input string tag, input int max);
    int k = 0;
    while (!bus.irq_valid && k < max) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_offer"}, 32'(bus.irq_valid), 32'd1);
  endtask

  task automatic quiet(input string tag, input int n);
    logic seen = 1'b0;
    repeat (n) begin
      if (bus.irq_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk({tag, "_quiet"}, 32'(seen), 32'd0);
  endtask

  task automatic accept(input string tag, input bit with_done);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, "_id"}, 32'(bus.irq_id), 32'(e.id));
    chk({tag, "_prio"}, 32'(bus.irq_prio), 32'(e.prio));
    bus.irq_ready = 1'b1;
    bus.irq_done  = with_done;
    @(negedge clk);
    bus.irq_ready = 1'b0;
    bus.irq_done  = 1'b0;
    chk({tag, "_drop"}, 32'(bus.irq_valid), 32'd0);
    chk({tag, "_level"}, 32'(cur_level), 32'(e.prio));
  endtask

  task automatic ret(input string tag, input int exp_lvl);
    bus.irq_done = 1'b1;
    @(negedge clk);
    bus.irq_done = 1'b0;
    chk({tag, "_ret"}, 32'(cur_level), 32'(exp_lvl));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int bp[8]  = '{8, 9, 6, 1, 5, 5, 7, 6};
    int ord[7] = '{0, 6, 2, 7, 4, 5, 3};

    reset = 1'b0;
    irq_in = '0;
    bus.irq_ready = 1'b0;
    bus.irq_done  = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_idx   = '0;
    bus.cfg_prio  = '0;
    bus.cfg_en    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(bus.irq_valid), 32'd0);
    chk("rst_id", 32'(bus.irq_id), 32'd0);
    chk("rst_prio", 32'(bus.irq_prio), 32'd0);
    chk("rst_level", 32'(cur_level), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // basic offer, then drain the rest in priority order (ties go to lower index)
    for (int i = 0; i < 8; i++) cfg(i, bp[i], 1'b1);
    push_exp(1, 9);
    for (int i = 0; i < 7; i++) push_exp(ord[i], bp[ord[i]]);
    pulse(8'hFF);
    lat2("basic");
    accept("basic_first", 1'b0);
    quiet("basic_nested", 4);
    ret("basic_first", 0);
    for (int i = 0; i < 7; i++) begin
      wait_offer("drain", 10);
      accept("drain", 1'b0);
      ret("drain", 0);
    end

    // explicit tie-break between sources 4 and 5
    push_exp(4, 5);
    push_exp(5, 5);
    pulse(8'h30);
    wait_offer("tie_a", 10);
    accept("tie_a", 1'b0);
    ret("tie_a", 0);
    wait_offer("tie_b", 10);
    accept("tie_b", 1'b0);
    ret("tie_b", 0);

    // preemption
    push_exp(2, 6);
    pulse(8'h04);
    wait_offer("pre_2", 10);
    accept("pre_2", 1'b0);
    pulse(8'h80);
    quiet("pre_equal", 6);
    push_exp(0, 8);
    pulse(8'h01);
    wait_offer("pre_0", 10);
    accept("pre_0", 1'b0);
    ret("pre_pop0", 6);
    ret("pre_pop2", 0);
    push_exp(7, 6);
    wait_offer("pre_7", 10);
    accept("pre_7", 1'b0);
    ret("pre_7", 0);

    // masking and priority-zero sources
    cfg(1, 9, 1'b0);
    pulse(8'h02);
    quiet("mask_en", 6);
    cfg(3, 0, 1'b1);
    pulse(8'h08);
    quiet("mask_p0", 6);
    push_exp(1, 9);
    cfg(1, 9, 1'b1);
    lat2("reenable");
    accept("reenable", 1'b0);
    ret("reenable", 0);
    push_exp(3, 1);
    cfg(3, 1, 1'b1);
    lat2("reprio");
    accept("reprio", 1'b0);
    ret("reprio", 0);

    // fill the nesting stack
    for (int i = 0; i < 8; i++) cfg(i, i + 1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      push_exp(i, i + 1);
      pulse(N_SRC'(1) << i);
      wait_offer("fill", 10);
      accept("fill", 1'b0);
    end
    cfg(0, 200, 1'b1);
    pulse(8'h01);
    quiet("full", 8);
    push_exp(0, 200);
    ret("full_pop", 7);
    wait_offer("full_after", 10);
    accept("full_after", 1'b0);
    for (int k = 7; k >= 0; k--) ret("unwind", k);
    chk("unwind_err", 32'(err), 32'd0);
    ret("empty_pop", 0);
    chk("empty_err", 32'(err), 32'd1);

    // asynchronous reset during an offer
    pulse(8'h01);
    wait_offer("rst_mid", 10);
    chk("rst_mid_id", 32'(bus.irq_id), 32'd0);
    chk("rst_mid_prio", 32'(bus.irq_prio), 32'd200);
    reset = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(bus.irq_valid), 32'd0);
    chk("rst_mid_oprio", 32'(bus.irq_prio), 32'd0);
    chk("rst_mid_level", 32'(cur_level), 32'd0);
    chk("rst_mid_err", 32'(err), 32'd0);
    irq_in = 8'h08;
    @(negedge clk);
    reset = 1'b1;
    quiet("post_rst", 6);

    // edge captured at release, then accept together with a return
    push_exp(3, 4);
    cfg(3, 4, 1'b1);
    lat2("rel_edge");
    accept("hs_done", 1'b1);
    chk("hs_done_err", 32'(err), 32'd1);
    ret("hs_done_pop", 0);
    irq_in = '0;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
